// File: rtl/ex_muldiv_pkg.sv
// Shared constants for the RV32M/RV64M multiply/divide unit: M-extension
// function codes, FSM state encodings and default parameters.
package ex_muldiv_pkg;

    localparam int DEFAULT_XLEN    = 32;
    localparam int DEFAULT_MUL_LAT = 2;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_MUL       = 3'd1;
    localparam logic [2:0] ST_DIV_SETUP = 3'd2;
    localparam logic [2:0] ST_DIV_ITER  = 3'd3;
    localparam logic [2:0] ST_DIV_FIX   = 3'd4;
    localparam logic [2:0] ST_DONE      = 3'd5;

    function automatic logic is_div_op(input logic [2:0] funct3);
        return funct3[2];
    endfunction

    // DIV and REM are signed; DIVU and REMU carry funct3[0] set.
    function automatic logic is_signed_div(input logic [2:0] funct3);
        return funct3[2] & ~funct3[0];
    endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// Execute-stage handshake to the multiply/divide unit: operation launch,
// abort, pipeline hold and the registered result.
interface ex_muldiv_if #(parameter int XLEN = 32);

    logic            start_i;
    logic [2:0]      funct3_i;
    logic [XLEN-1:0] rs1_i;
    logic [XLEN-1:0] rs2_i;
    logic [4:0]      wd_i;
    logic            flush_i;
    logic            stall_req_o;
    logic            busy_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;
    logic [4:0]      wd_o;
    logic            wreg_o;

    modport master (
        output start_i, funct3_i, rs1_i, rs2_i, wd_i, flush_i,
        input  stall_req_o, busy_o, done_o, result_o, wd_o, wreg_o
    );

    modport slave (
        input  start_i, funct3_i, rs1_i, rs2_i, wd_i, flush_i,
        output stall_req_o, busy_o, done_o, result_o, wd_o, wreg_o
    );

endinterface

// File: rtl/ex_muldiv_div_radix2.sv
// Unsigned radix-2 restoring divider. The load cycle already performs the
// first step, so XLEN steps finish XLEN edges after start.
module div_radix2 #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            start,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    localparam int CW = $clog2(XLEN + 1);

    logic [XLEN-1:0]   rem_r;
    logic [XLEN-1:0]   quo_r;
    logic [XLEN-1:0]   dsr_r;
    logic [CW-1:0]     cnt_r;
    logic              run_r;
    logic [2*XLEN-1:0] step_s;

    // One shift-compare-subtract step; returns {remainder, quotient/dividend}.
    function automatic logic [2*XLEN-1:0] div_step(
        input logic [XLEN-1:0] rem,
        input logic [XLEN-1:0] quo,
        input logic [XLEN-1:0] dsr
    );
        logic [XLEN:0] sh;
        logic [XLEN:0] diff;
        sh   = {rem, quo[XLEN-1]};
        diff = sh - {1'b0, dsr};
        if (sh >= {1'b0, dsr}) begin
            return {diff[XLEN-1:0], quo[XLEN-2:0], 1'b1};
        end else begin
            return {sh[XLEN-1:0], quo[XLEN-2:0], 1'b0};
        end
    endfunction

    // Select operands for this cycle's step: fresh load or running state.
    always_comb begin
        step_s = {2*XLEN{1'b0}};
        if (start) begin
            step_s = div_step({XLEN{1'b0}}, dividend, divisor);
        end else begin
            step_s = div_step(rem_r, quo_r, dsr_r);
        end
    end

    // Datapath and iteration counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_r <= {XLEN{1'b0}};
            quo_r <= {XLEN{1'b0}};
            dsr_r <= {XLEN{1'b0}};
            cnt_r <= {CW{1'b0}};
            run_r <= 1'b0;
        end else if (flush) begin
            run_r <= 1'b0;
            cnt_r <= {CW{1'b0}};
        end else if (start) begin
            rem_r <= step_s[2*XLEN-1:XLEN];
            quo_r <= step_s[XLEN-1:0];
            dsr_r <= divisor;
            cnt_r <= CW'(XLEN - 1);
            run_r <= 1'b1;
        end else if (run_r) begin
            rem_r <= step_s[2*XLEN-1:XLEN];
            quo_r <= step_s[XLEN-1:0];
            cnt_r <= cnt_r - CW'(1);
            run_r <= (cnt_r != CW'(1));
        end else begin
            run_r <= 1'b0;
        end
    end

    // High while the final step is being committed at the coming edge.
    assign done      = run_r & (cnt_r == CW'(1));
    assign quotient  = quo_r;
    assign remainder = rem_r;

endmodule

// File: rtl/ex_muldiv.sv
// Multi-cycle M-extension unit beside execute: pipelined multiply, iterative
// signed/unsigned divide with a one-cycle fast path for /0 and MIN/-1.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN    = DEFAULT_XLEN,
    parameter int MUL_LAT = DEFAULT_MUL_LAT
) (
    input logic        clk,
    input logic        rst,
    ex_muldiv_if.slave bus
);

    localparam int              CW      = $clog2(MUL_LAT + 1);
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    logic [2:0]        state_r;
    logic [2:0]        state_nxt_s;
    logic [2:0]        f3_r;
    logic [XLEN-1:0]   a_r;
    logic [XLEN-1:0]   b_r;
    logic [4:0]        wd_lat_r;
    logic [CW-1:0]     mul_cnt_r;
    logic              neg_q_r;
    logic              neg_r_r;
    logic [XLEN-1:0]   result_r;
    logic [4:0]        wd_r;
    logic              done_r;

    logic              launch_s;
    logic              busy_s;
    logic              fast_zero_s;
    logic              fast_ovf_s;
    logic [XLEN-1:0]   fast_res_s;
    logic [2*XLEN-1:0] op_a_s;
    logic [2*XLEN-1:0] op_b_s;
    logic [2*XLEN-1:0] prod_s;
    logic [2*XLEN-1:0] prod_tap_s;
    logic [XLEN-1:0]   mul_res_s;
    logic              a_neg_s;
    logic              b_neg_s;
    logic [XLEN-1:0]   abs_a_s;
    logic [XLEN-1:0]   abs_b_s;
    logic              div_done_s;
    logic [XLEN-1:0]   div_quo_s;
    logic [XLEN-1:0]   div_rem_s;
    logic [XLEN-1:0]   fix_res_s;
    logic [XLEN-1:0]   res_next_s;
    logic [4:0]        wd_next_s;

    assign launch_s    = (state_r == ST_IDLE) & bus.start_i & ~bus.flush_i;
    assign busy_s      = (state_r != ST_IDLE) & (state_r != ST_DONE);
    assign fast_zero_s = is_div_op(bus.funct3_i) & (bus.rs2_i == {XLEN{1'b0}});
    assign fast_ovf_s  = is_signed_div(bus.funct3_i) & (bus.rs1_i == MIN_VAL) &
                         (bus.rs2_i == {XLEN{1'b1}});

    // Fast-path result; funct3[1] distinguishes REM* from DIV*.
    always_comb begin
        fast_res_s = {XLEN{1'b0}};
        if (fast_zero_s) begin
            fast_res_s = bus.funct3_i[1] ? bus.rs1_i : {XLEN{1'b1}};
        end else if (fast_ovf_s) begin
            fast_res_s = bus.funct3_i[1] ? {XLEN{1'b0}} : MIN_VAL;
        end else begin
            fast_res_s = {XLEN{1'b0}};
        end
    end

    // Sign-extending to 2*XLEN keeps the low 2*XLEN product bits exact for
    // every signedness combination.
    assign op_a_s = {{XLEN{a_r[XLEN-1] & ((f3_r == F3_MULH) | (f3_r == F3_MULHSU))}}, a_r};
    assign op_b_s = {{XLEN{b_r[XLEN-1] & (f3_r == F3_MULH)}}, b_r};
    assign prod_s = op_a_s * op_b_s;

    generate
        if (MUL_LAT == 1) begin : g_no_pipe
            assign prod_tap_s = prod_s;
        end else begin : g_pipe
            logic [2*XLEN-1:0] pipe_r [MUL_LAT-1];

            // Product retiming stages; the result register is the last stage.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < MUL_LAT - 1; i++) begin
                        pipe_r[i] <= {2*XLEN{1'b0}};
                    end
                end else begin
                    pipe_r[0] <= prod_s;
                    for (int i = 1; i < MUL_LAT - 1; i++) begin
                        pipe_r[i] <= pipe_r[i-1];
                    end
                end
            end

            assign prod_tap_s = pipe_r[MUL_LAT-2];
        end
    endgenerate

    assign mul_res_s = (f3_r == F3_MUL) ? prod_tap_s[XLEN-1:0] : prod_tap_s[2*XLEN-1:XLEN];

    assign a_neg_s = is_signed_div(f3_r) & a_r[XLEN-1];
    assign b_neg_s = is_signed_div(f3_r) & b_r[XLEN-1];
    assign abs_a_s = a_neg_s ? ({XLEN{1'b0}} - a_r) : a_r;
    assign abs_b_s = b_neg_s ? ({XLEN{1'b0}} - b_r) : b_r;

    div_radix2 #(.XLEN(XLEN)) u_div (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.flush_i),
        .start     (state_r == ST_DIV_SETUP),
        .dividend  (abs_a_s),
        .divisor   (abs_b_s),
        .done      (div_done_s),
        .quotient  (div_quo_s),
        .remainder (div_rem_s)
    );

    // Sign correction of the unsigned divider outputs.
    always_comb begin
        fix_res_s = {XLEN{1'b0}};
        if (f3_r[1]) begin
            fix_res_s = neg_r_r ? ({XLEN{1'b0}} - div_rem_s) : div_rem_s;
        end else begin
            fix_res_s = neg_q_r ? ({XLEN{1'b0}} - div_quo_s) : div_quo_s;
        end
    end

    // Next-state logic; a flush outside IDLE always wins.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!launch_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (!is_div_op(bus.funct3_i)) begin
                    state_nxt_s = ST_MUL;
                end else if (fast_zero_s | fast_ovf_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_DIV_SETUP;
                end
            end
            ST_MUL:       state_nxt_s = (mul_cnt_r == CW'(MUL_LAT - 1)) ? ST_DONE : ST_MUL;
            ST_DIV_SETUP: state_nxt_s = ST_DIV_ITER;
            ST_DIV_ITER:  state_nxt_s = div_done_s ? ST_DIV_FIX : ST_DIV_ITER;
            ST_DIV_FIX:   state_nxt_s = ST_DONE;
            ST_DONE:      state_nxt_s = ST_IDLE;
            default:      state_nxt_s = ST_IDLE;
        endcase
        if (bus.flush_i && (state_r != ST_IDLE)) begin
            state_nxt_s = ST_IDLE;
        end else begin
            state_nxt_s = state_nxt_s;
        end
    end

    // Result source for the edge that enters DONE.
    always_comb begin
        res_next_s = result_r;
        wd_next_s  = wd_r;
        case (state_r)
            ST_IDLE: begin
                res_next_s = fast_res_s;
                wd_next_s  = bus.wd_i;
            end
            ST_MUL: begin
                res_next_s = mul_res_s;
                wd_next_s  = wd_lat_r;
            end
            ST_DIV_FIX: begin
                res_next_s = fix_res_s;
                wd_next_s  = wd_lat_r;
            end
            default: begin
                res_next_s = result_r;
                wd_next_s  = wd_r;
            end
        endcase
    end

    // FSM, operand latches, sign flags and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            f3_r      <= 3'b000;
            a_r       <= {XLEN{1'b0}};
            b_r       <= {XLEN{1'b0}};
            wd_lat_r  <= 5'd0;
            mul_cnt_r <= {CW{1'b0}};
            neg_q_r   <= 1'b0;
            neg_r_r   <= 1'b0;
            result_r  <= {XLEN{1'b0}};
            wd_r      <= 5'd0;
            done_r    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            done_r  <= (state_nxt_s == ST_DONE);
            if (launch_s) begin
                f3_r      <= bus.funct3_i;
                a_r       <= bus.rs1_i;
                b_r       <= bus.rs2_i;
                wd_lat_r  <= bus.wd_i;
                mul_cnt_r <= {CW{1'b0}};
            end else if (state_r == ST_MUL) begin
                mul_cnt_r <= mul_cnt_r + CW'(1);
            end else begin
                mul_cnt_r <= mul_cnt_r;
            end
            if (state_r == ST_DIV_SETUP) begin
                neg_q_r <= a_neg_s ^ b_neg_s;
                neg_r_r <= a_neg_s;
            end else begin
                neg_q_r <= neg_q_r;
                neg_r_r <= neg_r_r;
            end
            if (state_nxt_s == ST_DONE) begin
                result_r <= res_next_s;
                wd_r     <= wd_next_s;
            end else begin
                result_r <= result_r;
                wd_r     <= wd_r;
            end
        end
    end

    // Reset gating keeps the hold request low while rst is asserted.
    assign bus.stall_req_o = ~rst & (launch_s | busy_s);
    assign bus.busy_o      = busy_s;
    assign bus.done_o      = done_r;
    assign bus.wreg_o      = done_r;
    assign bus.result_o    = result_r;
    assign bus.wd_o        = wd_r;

endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: XLEN=32 and XLEN=64 instances against an arithmetic
// reference model, plus directed corner, flush and reset scenarios.
module tb_ex_muldiv;
    import ex_muldiv_pkg::*;

    localparam int LAT32 = 2;
    localparam int LAT64 = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    logic [63:0] last_res [2];
    logic [4:0]  last_wd  [2];

    always #5 clk = ~clk;

    ex_muldiv_if #(.XLEN(32)) if32 ();
    ex_muldiv_if #(.XLEN(64)) if64 ();

    ex_muldiv #(.XLEN(32), .MUL_LAT(LAT32)) dut32 (.clk(clk), .rst(rst), .bus(if32.slave));
    ex_muldiv #(.XLEN(64), .MUL_LAT(LAT64)) dut64 (.clk(clk), .rst(rst), .bus(if64.slave));

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit w64, input logic st, input logic fl, input logic [2:0] f3,
                         input logic [63:0] a, input logic [63:0] b, input logic [4:0] wd);
        if (w64) begin
            if64.start_i = st; if64.flush_i = fl; if64.funct3_i = f3;
            if64.rs1_i = a; if64.rs2_i = b; if64.wd_i = wd;
        end else begin
            if32.start_i = st; if32.flush_i = fl; if32.funct3_i = f3;
            if32.rs1_i = a[31:0]; if32.rs2_i = b[31:0]; if32.wd_i = wd;
        end
    endtask

    function automatic logic [63:0] obs_res(input bit w64);
        return w64 ? if64.result_o : {32'h0, if32.result_o};
    endfunction
    function automatic logic obs_done(input bit w64);  return w64 ? if64.done_o : if32.done_o;           endfunction
    function automatic logic obs_stall(input bit w64); return w64 ? if64.stall_req_o : if32.stall_req_o; endfunction
    function automatic logic obs_busy(input bit w64);  return w64 ? if64.busy_o : if32.busy_o;           endfunction
    function automatic logic obs_wreg(input bit w64);  return w64 ? if64.wreg_o : if32.wreg_o;           endfunction
    function automatic logic [4:0] obs_wd(input bit w64); return w64 ? if64.wd_o : if32.wd_o;            endfunction

    function automatic logic [63:0] width_mask(input bit w64);
        return w64 ? {64{1'b1}} : 64'h0000_0000_ffff_ffff;
    endfunction

    // Reference: plain 128-bit arithmetic on sign/zero-extended operands.
    function automatic logic [63:0] model(input bit w64, input logic [2:0] f3,
                                          input logic [63:0] a_in, input logic [63:0] b_in);
        logic [63:0] mask, a, b;
        logic signed [127:0] sa, sb, ua, ub, r;
        int n;
        mask = width_mask(w64);
        n    = w64 ? 64 : 32;
        a    = a_in & mask;
        b    = b_in & mask;
        sa   = w64 ? {{64{a[63]}}, a} : {{96{a[31]}}, a[31:0]};
        sb   = w64 ? {{64{b[63]}}, b} : {{96{b[31]}}, b[31:0]};
        ua   = {64'd0, a};
        ub   = {64'd0, b};
        r    = '0;
        case (f3)
            3'd0: r = ua * ub;
            3'd1: r = (sa * sb) >>> n;
            3'd2: r = (sa * ub) >>> n;
            3'd3: r = (ua * ub) >>> n;
            3'd4: if (b == 64'd0) r = {128{1'b1}}; else r = sa / sb;
            3'd5: if (b == 64'd0) r = {128{1'b1}}; else r = ua / ub;
            3'd6: if (b == 64'd0) r = sa; else r = sa % sb;
            default: if (b == 64'd0) r = ua; else r = ua % ub;
        endcase
        return r[63:0] & mask;
    endfunction

    function automatic int exp_lat(input bit w64, input logic [2:0] f3,
                                   input logic [63:0] a, input logic [63:0] b);
        logic [63:0] mask, minv;
        mask = width_mask(w64);
        minv = w64 ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
        if (!f3[2]) return (w64 ? LAT64 : LAT32) + 1;
        if ((b & mask) == 64'd0) return 1;
        if (!f3[0] && ((a & mask) == minv) && ((b & mask) == mask)) return 1;
        return (w64 ? 64 : 32) + 2;
    endfunction

    task automatic do_op(input bit w64, input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] exp, input logic [4:0] wd,
                         input string tag);
        int n;
        bit stall_ok;
        logic [63:0] mask;
        mask = width_mask(w64);
        @(negedge clk);
        drive(w64, 1'b1, 1'b0, f3, a, b, wd);
        #1;
        chk_eq({tag, "_stall_launch"}, 64'(obs_stall(w64)), 64'd1);
        @(posedge clk);
        #1;
        drive(w64, 1'b0, 1'b0, 3'b000, 64'd0, 64'd0, 5'd0);
        n = 1;
        stall_ok = 1'b1;
        while (!obs_done(w64) && n < 200) begin
            if (obs_stall(w64) !== 1'b1) stall_ok = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
        chk_eq({tag, "_latency"}, 64'(n), 64'(exp_lat(w64, f3, a, b)));
        chk_eq({tag, "_stall_busy"}, 64'(stall_ok), 64'd1);
        chk_eq({tag, "_result"}, obs_res(w64), exp & mask);
        chk_eq({tag, "_wd"}, 64'(obs_wd(w64)), 64'(wd));
        chk_eq({tag, "_wreg"}, 64'(obs_wreg(w64)), 64'd1);
        chk_eq({tag, "_stall_done"}, 64'(obs_stall(w64)), 64'd0);
        chk_eq({tag, "_busy_done"}, 64'(obs_busy(w64)), 64'd0);
        @(posedge clk);
        #1;
        chk_eq({tag, "_done_pulse"}, 64'(obs_done(w64)), 64'd0);
        chk_eq({tag, "_hold"}, obs_res(w64), exp & mask);
        last_res[w64] = exp & mask;
        last_wd[w64]  = wd;
    endtask

    initial begin
        bit seen_done;
        drive(1'b0, 1'b0, 1'b0, 3'b000, 64'd0, 64'd0, 5'd0);
        drive(1'b1, 1'b0, 1'b0, 3'b000, 64'd0, 64'd0, 5'd0);
        repeat (2) @(posedge clk);
        #1;
        for (int w = 0; w < 2; w++) begin
            chk_eq("rst_stall", 64'(obs_stall(w[0])), 64'd0);
            chk_eq("rst_busy",  64'(obs_busy(w[0])),  64'd0);
            chk_eq("rst_done",  64'(obs_done(w[0])),  64'd0);
            chk_eq("rst_wreg",  64'(obs_wreg(w[0])),  64'd0);
            chk_eq("rst_res",   obs_res(w[0]),        64'd0);
            chk_eq("rst_wd",    64'(obs_wd(w[0])),    64'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        do_op(0, F3_MUL,    64'h7,        64'hFFFFFFFD, 64'hFFFFFFEB, 5'd1,  "mul");
        do_op(0, F3_MULH,   64'hFFFFFFFF, 64'hFFFFFFFF, 64'h00000000, 5'd2,  "mulh_m1");
        do_op(0, F3_MULHSU, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFF, 5'd3,  "mulhsu_m1");
        do_op(0, F3_MULHU,  64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFE, 5'd4,  "mulhu_m1");
        do_op(0, F3_MULH,   64'h80000000, 64'h80000000, 64'h40000000, 5'd5,  "mulh_min");
        do_op(0, F3_DIV,    64'hFFFFFFF9, 64'h2,        64'hFFFFFFFD, 5'd6,  "div_neg");
        do_op(0, F3_REM,    64'hFFFFFFF9, 64'h2,        64'hFFFFFFFF, 5'd7,  "rem_neg");
        do_op(0, F3_DIVU,   64'd100,      64'd7,        64'd14,       5'd8,  "divu");
        do_op(0, F3_REMU,   64'd100,      64'd7,        64'd2,        5'd9,  "remu");
        do_op(0, F3_DIVU,   64'd5,        64'd0,        64'hFFFFFFFF, 5'd10, "divu_z");
        do_op(0, F3_REMU,   64'd5,        64'd0,        64'd5,        5'd11, "remu_z");
        do_op(0, F3_DIV,    64'h80000000, 64'hFFFFFFFF, 64'h80000000, 5'd12, "div_ovf");
        do_op(0, F3_REM,    64'h80000000, 64'hFFFFFFFF, 64'd0,        5'd13, "rem_ovf");

        do_op(1, F3_DIV,  64'hFFFFFFFFFFFFFFF9, 64'h2, 64'hFFFFFFFFFFFFFFFD, 5'd14, "div64_neg");
        do_op(1, F3_REM,  64'hFFFFFFFFFFFFFFF9, 64'h2, 64'hFFFFFFFFFFFFFFFF, 5'd15, "rem64_neg");
        do_op(1, F3_DIVU, 64'd100, 64'd7, 64'd14, 5'd16, "divu64");
        do_op(1, F3_REMU, 64'd100, 64'd7, 64'd2,  5'd17, "remu64");
        do_op(1, F3_DIVU, 64'd5,   64'd0, 64'hFFFFFFFFFFFFFFFF, 5'd18, "divu64_z");
        do_op(1, F3_REMU, 64'd5,   64'd0, 64'd5,  5'd19, "remu64_z");
        do_op(1, F3_DIV,  64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 64'h8000000000000000, 5'd20, "div64_ovf");
        do_op(1, F3_REM,  64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 64'd0, 5'd21, "rem64_ovf");

        // Flush in cycle 10 of a divide, then a multiply launched in cycle 11.
        @(negedge clk);
        drive(0, 1'b1, 1'b0, F3_DIV, 64'd1000, 64'd7, 5'd22);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 1'b0, 3'b000, 64'd0, 64'd0, 5'd0);
        seen_done = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            @(posedge clk);
            #1;
            if (if32.done_o) seen_done = 1'b1;
        end
        if32.flush_i = 1'b1;
        @(posedge clk);
        #1;
        if32.flush_i = 1'b0;
        chk_eq("flush_busy", 64'(if32.busy_o), 64'd0);
        chk_eq("flush_done", 64'(seen_done | if32.done_o), 64'd0);
        chk_eq("flush_res_kept", obs_res(0), last_res[0]);
        chk_eq("flush_wd_kept", 64'(if32.wd_o), 64'(last_wd[0]));
        do_op(0, F3_MUL, 64'd1234, 64'd5678, 64'd7006652, 5'd23, "mul_after_flush");

        // start together with flush in IDLE must not launch.
        @(negedge clk);
        drive(0, 1'b1, 1'b1, F3_DIVU, 64'd100, 64'd7, 5'd24);
        #1;
        chk_eq("sf_stall", 64'(if32.stall_req_o), 64'd0);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 1'b0, 3'b000, 64'd0, 64'd0, 5'd0);
        chk_eq("sf_busy", 64'(if32.busy_o), 64'd0);
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (if32.done_o) seen_done = 1'b1;
        end
        chk_eq("sf_no_done", 64'(seen_done), 64'd0);

        // Asynchronous reset in the middle of the divide iterations.
        @(negedge clk);
        drive(0, 1'b1, 1'b0, F3_DIV, 64'd1000, 64'd3, 5'd25);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 1'b0, 3'b000, 64'd0, 64'd0, 5'd0);
        repeat (15) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk_eq("arst_busy",  64'(if32.busy_o),      64'd0);
        chk_eq("arst_stall", 64'(if32.stall_req_o), 64'd0);
        chk_eq("arst_done",  64'(if32.done_o),      64'd0);
        chk_eq("arst_wreg",  64'(if32.wreg_o),      64'd0);
        chk_eq("arst_res",   obs_res(0),            64'd0);
        chk_eq("arst_wd",    64'(if32.wd_o),        64'd0);
        @(negedge clk);
        rst = 1'b0;
        do_op(0, F3_DIV, 64'd1000, 64'd3, 64'd333, 5'd26, "div_after_rst");

        // Randomised operations biased towards divide corner cases.
        for (int i = 0; i < 48; i++) begin
            bit w;
            logic [2:0]  f3;
            logic [63:0] a, b;
            int sel;
            w   = (i % 4 == 3);
            f3  = 3'($urandom_range(0, 7));
            a   = {$urandom(), $urandom()};
            b   = {$urandom(), $urandom()};
            sel = $urandom_range(0, 5);
            if (sel == 0) b = 64'd0;
            if (sel == 1) begin
                a = w ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
                b = {64{1'b1}};
            end
            if (sel == 2) b = b & 64'h0000_0000_0000_00FF;
            if (sel == 3) a = a | 64'h8000_0000_8000_0000;
            do_op(w, f3, a, b, model(w, f3, a, b), 5'($urandom_range(0, 31)), "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Multi-cycle RV32M/RV64M multiply/divide unit that sits beside the single-cycle execute stage. Execute hands it one M-extension operation (`funct7 == 0000001`, opcode `EXE`). It holds the pipeline with a stall request while it works, then returns one registered result with its destination register. Width and multiplier latency are parametrised, and divide-by-zero and overflow complete on a fast path.

## Interface
- `XLEN`, default 32: operand/result width; 32 or 64.
- `MUL_LAT`, default 2: multiply pipeline depth in cycles, legal range 1..4.
- `clk` in 1: rising-edge clock.
- `rst` in 1: one clock; reset is asynchronous and active-high.
- `start_i` in 1: launch request; sampled only in IDLE.
- `funct3_i` in 3: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
- `rs1_i` in XLEN: first operand.
- `rs2_i` in XLEN: second operand.
- `wd_i` in 5: destination register.
- `flush_i` in 1: synchronous abort.
- `stall_req_o` out 1: pipeline hold request to control.
- `busy_o` out 1: state is neither IDLE nor DONE.
- `done_o` out 1: one-cycle result-valid pulse.
- `result_o` out XLEN: result.
- `wd_o` out 5: destination register for the result.
- `wreg_o` out 1: write enable; equals `done_o`.

## Operation
- States:
  - IDLE: waits for `start_i`.
  - MUL: counts `MUL_LAT` cycles.
  - DIV_SETUP: takes absolute values and latches the result signs.
  - DIV_ITER: runs `XLEN` radix-2 restoring steps.
  - DIV_FIX: applies sign correction.
  - DONE: presents the result for one cycle, then returns to IDLE.
- Launch:
  - IDLE with `start_i` high and `flush_i` low: latch operands, `funct3_i` and `wd_i`.
  - Then go to MUL, DIV_SETUP, or DONE (fast path).
- Multiply: both operands are extended to XLEN+1 bits, giving a 2·XLEN product.
  - MUL: low half.
  - MULH: signed×signed, high half.
  - MULHSU: rs1 signed × rs2 unsigned, high half.
  - MULHU: unsigned×unsigned, high half.
- Divide, signed: the quotient is negative iff the operand signs differ; the remainder takes the dividend's sign.
- Fast path (DONE next cycle):
  - Divisor zero: quotient all-ones, remainder = dividend.
  - Signed `MIN/-1`: quotient = MIN, remainder = 0.
- `stall_req_o` = (IDLE & `start_i` & !`flush_i`) | `busy_o`. It is low in DONE so execute captures the result that cycle.
- `start_i` is ignored outside IDLE.
- `flush_i`:
  - In any state except IDLE, it returns the unit to IDLE at the next edge; no `done_o` is issued for the aborted operation.
  - It takes priority over `start_i` in the same cycle.
  - It leaves `result_o` and `wd_o` unchanged.
- `rst`: immediate return to IDLE from any state; all outputs and internal registers cleared.

## Timing
- Reset values: `stall_req_o` 0, `busy_o` 0, `done_o` 0, `wreg_o` 0, `result_o` 0, `wd_o` 0.
- Cycle 0 is the edge that samples `start_i`.
- `done_o` latency:
  - MUL*: asserted after `MUL_LAT`+1 edges.
  - DIV*/REM*: after `XLEN`+2 edges (34 for XLEN=32).
  - Fast path: after 1 edge.
- `result_o`, `wd_o` and `wreg_o` are registered, valid while `done_o` is high, and hold their value afterwards until the next DONE.
- Back-to-back: a new `start_i` is accepted in the cycle after DONE; DONE→launch costs one idle cycle.
- `stall_req_o` is combinational from `start_i` only in IDLE. In every other state it is a function of state only.

## Structure
- `defs.v` gains:
  - M-extension `funct3` codes MUL..REMU.
  - `funct7` MULDIV code `7'b0000001`.
  - State encodings.
  - Default `XLEN` and `MUL_LAT`.
- Sub-module `div_radix2`:
  - Owns the unsigned iterative quotient/remainder datapath and the iteration counter.
  - Ports: start, dividend, divisor, done.
- The multiply pipeline, sign handling, fast path and FSM stay in `ex_muldiv`.

## Test plan
- MUL 7 × 0xFFFFFFFD, MUL_LAT=2 → `result_o` 0xFFFFFFEB, `done_o` at cycle 3; `stall_req_o` high cycles 0–2.
- 0xFFFFFFFF × 0xFFFFFFFF:
  - MULH → 0x00000000.
  - MULHSU → 0xFFFFFFFF.
  - MULHU → 0xFFFFFFFE.
- MULH 0x80000000 × 0x80000000 → 0x40000000.
- Sign handling, `done_o` at cycle 34:
  - DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD.
  - REM 0xFFFFFFF9 % 2 → 0xFFFFFFFF.
  - DIVU 100 / 7 → 14.
  - REMU 100 % 7 → 2.
- Fast path, each with `done_o` at cycle 1:
  - DIVU 5 / 0 → 0xFFFFFFFF.
  - REMU 5 % 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
- Flush and restart:
  - `flush_i` at cycle 10 of a DIV → IDLE at cycle 11, no `done_o`.
  - A MUL started at cycle 11 completes normally.
  - `start_i` and `flush_i` together in IDLE → not accepted.
- Reset and width:
  - `rst` pulsed mid-DIV_ITER → all outputs 0 without waiting for a clock edge; the next DIV is correct.
  - Repeat the divide set with XLEN=64, expecting `done_o` at cycle 66.
